// File: rtl/alu_shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA sequencer driving a one-bit-per-operation ALU.
// Optional macro SHIFT_EARLY_EXIT_EN: leave SHIFT as soon as acc is a fixed point of the shift.
module alu_shift_sequencer #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [n-1:0] operand,
    input  logic [4:0]   shamt,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] result,
    output logic [n-1:0] alu_a,
    output logic [n-1:0] alu_b,
    output logic [3:0]   alu_control,
    input  logic [n-1:0] alu_out
);

    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_PASS = 4'b1111;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t       state_q, state_d;
    logic [n-1:0] acc_q, acc_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [3:0]   code_q, code_d;
    logic [n-1:0] result_q, result_d;

    function automatic logic [3:0] op_to_code(input logic [1:0] o);
        case (o)
            2'b00:   return ALU_SLL;
            2'b01:   return ALU_SRL;
            2'b10:   return ALU_SRA;
            default: return ALU_PASS;
        endcase
    endfunction

`ifdef SHIFT_EARLY_EXIT_EN
    function automatic logic is_fixed(input logic [3:0] code, input logic [n-1:0] v);
        if (v == '0)
            return 1'b1;
        return (code == ALU_SRA) && (v == '1);
    endfunction
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            code_q   <= ALU_PASS;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            result_q <= result_d;
        end
    end

    // result is loaded on the edge entering DONE so it is already valid alongside done
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d  = operand;
                    cnt_d  = shamt;
                    code_d = op_to_code(op);
                    if (shamt == 5'd0 || op == 2'b11) begin
                        state_d  = DONE;
                        result_d = operand;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
`ifdef SHIFT_EARLY_EXIT_EN
                if (is_fixed(code_q, acc_q)) begin
                    state_d  = DONE;
                    result_d = acc_q;
                end else
`endif
                begin
                    acc_d = alu_out;
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_d  = DONE;
                        result_d = alu_out;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);
        alu_control = (state_q == SHIFT) ? code_q : ALU_PASS;
        alu_a       = acc_q;
        alu_b       = '0;
        result      = result_q;
    end

endmodule

// File: doc/alu_shift_sequencer.md
# alu_shift_sequencer

- Multi-cycle shift controller that acts as the driving end of the ALU operand/control interface.
- The ALU only shifts by one bit per operation; this block performs RV32I SLL/SRL/SRA by an arbitrary 5-bit shift amount.
- It repeatedly issues single-bit shift operations to `ALU_nbit` and feeds `ALUout` back as the next operand.
- It sits between the execute-stage control and the ALU, and stalls the pipeline through `busy` while a shift is in progress.

## Interface

Parameters:
- `n`, 32, datapath width; must match the `n` of the attached `ALU_nbit`.

Ports:
- `clk` in 1: single clock, rising-edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: request; sampled only while `busy`=0.
- `op` in 2: shift type. 00=SLL, 01=SRL, 10=SRA, 11=pass.
- `operand` in n: value to shift; sampled with `start`.
- `shamt` in 5: shift amount; sampled with `start`.
- `busy` out 1: high while a request is in flight; new `start` is ignored.
- `done` out 1: one-cycle pulse; `result` is valid in that cycle.
- `result` out n: shifted value, held until the next accepted `start`.
- `alu_a` out n: drives ALU `A`.
- `alu_b` out n: drives ALU `B`; constant 0.
- `alu_control` out 4: drives ALU `alu_control`, using the `ALU_SLL`/`ALU_SRL`/`ALU_SRA`/`ALU_PASS` codes from `defines.v`.
- `alu_out` in n: ALU `ALUout` fed back. ALU flags are not used.

## Operation

- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - `start`=1 latches `acc`←`operand`, `cnt`←`shamt`, and the shift type.
  - If `shamt`=0 or `op`=11, go to DONE; no shift is issued.
  - Otherwise go to SHIFT.
- **SHIFT**
  - `alu_a`=`acc`; `alu_control`=the latched shift code.
  - Each cycle: `acc`←`alu_out`, `cnt`←`cnt`-1.
  - When `cnt`=1, go to DONE. The ALU is combinational, so there is exactly one shift per cycle.
- **DONE**
  - `result`←`acc`; `done`=1 for this cycle only; return to IDLE.
- **Outputs by state**
  - `busy`=1 in SHIFT and DONE; 0 in IDLE.
  - Outside SHIFT: `alu_control`=`ALU_PASS`, `alu_a`=`acc`.
- **Arithmetic**
  - Width is exactly n; shamt is unsigned 0–31.
  - SRA sign fill comes from the ALU, using `acc[n-1]` each step.
- **Boundaries**
  - `start` while `busy`=1: ignored; latched fields are unchanged.
  - `start` during DONE: ignored. The earliest next accept is the cycle after `done`.
  - `op`=11 with any `shamt`: `result`=`operand`, same latency as `shamt`=0.
  - Reset asserted mid-operation: immediately return to IDLE; no `done` pulse; `result` cleared.
- **Reset values**
  - state=IDLE, `busy`=0, `done`=0, `result`=0.
  - `acc`=0, `cnt`=0, `alu_a`=0, `alu_b`=0, `alu_control`=`ALU_PASS`.

## Timing

- Accept edge = edge E0 where IDLE samples `start`=1.
- Shift path: SHIFT occupies E0+1 … E0+shamt; `done`/`result` are valid in the cycle after edge E0+shamt.
  - Latency is shamt+1 cycles from accept to `done`.
- Zero-shift or pass path: `done` is valid in the cycle after E0 (1 cycle).
- Throughput: one request per latency+1 cycles.
- ALU path is combinational: `alu_out` must settle within the same cycle, `alu_a` → ALU → `acc` register.

## Configuration

- Macro: `SHIFT_EARLY_EXIT_EN`.
- **Defined:** in SHIFT, if `acc` is a fixed point of the operation, go to DONE on that edge without further shifting. Fixed points:
  - 0 for SLL/SRL;
  - 0 or all-ones for SRA.
  - `result` is identical to the non-early-exit result; only the latency shrinks.
- **Undefined:** always exactly shamt SHIFT cycles.

## Test plan

- Basic SLL: SLL, `operand`=0x0000_0001, `shamt`=4 → `done` 5 cycles after accept, `result`=0x0000_0010; `busy` high for 5 cycles.
- Full-width SRA: SRA, 0x8000_0000, `shamt`=31 → `result`=0xFFFF_FFFF, `done` 32 cycles after accept.
- Zero shift: SRL, 0xF000_0000, `shamt`=0 → `done` 1 cycle after accept, `result`=0xF000_0000, `alu_control` never leaves `ALU_PASS`.
- Start while busy: SRL, 0x0000_0100, `shamt`=8, then a second `start` (SLL, 0xFFFF_FFFF, 3) at cycle 3 → ignored; `result`=0x0000_0001 at cycle 9; no second `done`.
- Reset mid-shift: SLL, 0x1, `shamt`=10, `rst` low at cycle 4 → `busy`=0, `result`=0 immediately, no `done`; a new request after release completes normally.
- Macro check: SLL, 0x0000_0000, `shamt`=20 → with `SHIFT_EARLY_EXIT_EN`, `done` at cycle 2; without it, cycle 21; `result`=0 in both.
